reg_write_scoreboard: RTL and testbench

- Producer-side companion to the EXE/MEM bypass selection logic: tracks every in-flight GPR write from ID issue until WB retire.
- Tells ID, per source operand, whether the value is still in flight and whether it is forwardable yet, or ID must stall.
- Sits in ID. Fed by issue, pipeline-advance, long-op completion, WB retire and flush events.

---
 rtl/reg_write_scoreboard.sv | 129 ++++++++++++
 tb/tb_reg_write_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_write_scoreboard
//
// Tracks every in-flight GPR write from the moment it leaves ID until WB
// retires it. For the two source operands being decoded in ID, it reports
// whether a write is still in flight and whether that result can already be
// forwarded. If the result cannot be forwarded yet, ID must stall.
//
// Each register r in 1..NREG-1 holds three pieces of state:
//   pend - a write to r is in flight
//   long - the writer is a multi-cycle MDU op. Its result is not
//          forwardable until long_done arrives.
//   cnt  - the number of pipeline advances left before the result becomes
//          forwardable.
// Register 0 is never tracked.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   issue_valid/_wr     an instruction leaves ID and writes a GPR
//   issue_dst/_lat/_long destination, advances-to-forwardable, MDU flag
//   pipe_adv            the downstream pipeline advances; 0 freezes countdowns
//   long_done/long_dst  the MDU result has been written back
//   retire_valid/_dst   WB commits a register write
//   flush               squashes every in-flight write
//   id_rs, id_rt        operands queried in ID
//   rs_/rt_pending      the operand has an in-flight writer
//   rs_/rt_stall        the writer exists but is not forwardable yet
//   busy_any            at least one register is pending
// ---------------------------------------------------------------------------
module reg_write_scoreboard #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [4:0]      issue_dst,
  input  logic [CNTW-1:0] issue_lat,
  input  logic            issue_long,
  input  logic            pipe_adv,
  input  logic            long_done,
  input  logic [4:0]      long_dst,
  input  logic            retire_valid,
  input  logic [4:0]      retire_dst,
  input  logic            flush,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  output logic            rs_pending,
  output logic            rt_pending,
  output logic            rs_stall,
  output logic            rt_stall,
  output logic            busy_any
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] long_q, long_d;
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];

  // Next-state logic for every register. Within one register, each step
  // below may overwrite the result of the step before it, so the step
  // written last has the highest priority:
  //   countdown < long_done < retire < issue.
  // Flush sits outside all of this and overrides everything.
  // Because an issue on this edge replaces the decremented value, a newly
  // issued entry is never counted down on the edge that loads it.
  always_comb begin
    pend_d = pend_q;
    long_d = long_q;
    cnt_d  = cnt_q;
    if (flush) begin
      pend_d = '0;
      long_d = '0;
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (pipe_adv && pend_q[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNTW'(1);
        end
        if (long_done && (long_dst == 5'(r))) begin
          long_d[r] = 1'b0;
        end
        if (retire_valid && (retire_dst == 5'(r))) begin
          pend_d[r] = 1'b0;
          long_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end
        if (issue_valid && issue_wr && (issue_dst == 5'(r))) begin
          pend_d[r] = 1'b1;
          long_d[r] = issue_long;
          cnt_d[r]  = issue_lat;
        end
      end
    end
  end

  // State register. Reset is asynchronous, so asserting it clears every
  // entry at once, and the query outputs drop without waiting for a clock
  // edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      long_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      long_q <= long_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Zero-latency queries computed from the current state. The explicit
  // check for register 0 keeps r0 reading as "not pending" no matter what.
  always_comb begin
    rs_pending = pend_q[id_rs] & (id_rs != 5'd0);
    rt_pending = pend_q[id_rt] & (id_rt != 5'd0);
    rs_stall   = rs_pending & ((cnt_q[id_rs] != '0) | long_q[id_rs]);
    rt_stall   = rt_pending & ((cnt_q[id_rt] != '0) | long_q[id_rt]);
    busy_any   = |pend_q;
  end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
module tb_reg_write_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic       issue_wr;
  logic [4:0] issue_dst;
  logic [1:0] issue_lat;
  logic       issue_long;
  logic       pipe_adv;
  logic       long_done;
  logic [4:0] long_dst;
  logic       retire_valid;
  logic [4:0] retire_dst;
  logic       flush;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       rs_pending;
  logic       rt_pending;
  logic       rs_stall;
  logic       rt_stall;
  logic       busy_any;

  reg_write_scoreboard #(.NREG(32), .CNTW(2)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_wr(issue_wr),
    .issue_dst(issue_dst),
    .issue_lat(issue_lat),
    .issue_long(issue_long),
    .pipe_adv(pipe_adv),
    .long_done(long_done),
    .long_dst(long_dst),
    .retire_valid(retire_valid),
    .retire_dst(retire_dst),
    .flush(flush),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .rs_pending(rs_pending),
    .rt_pending(rt_pending),
    .rs_stall(rs_stall),
    .rt_stall(rt_stall),
    .busy_any(busy_any)
  );

  typedef struct {
    logic       iv;
    logic       iw;
    logic [4:0] idst;
    logic [1:0] ilat;
    logic       il;
    logic       adv;
    logic       ld;
    logic [4:0] ldst;
    logic       rv;
    logic [4:0] rdst;
    logic       fl;
    logic [4:0] rs;
    logic [4:0] rt;
  } stim_t;

  typedef struct {
    logic rsP;
    logic rtP;
    logic rsS;
    logic rtS;
    logic busy;
  } exp_t;

  // Reference model: one entry per architectural register, kept as plain
  // integers.
  int   modelPend [32];
  int   modelLong [32];
  int   modelCnt  [32];
  exp_t expQ [$];

  int checksTotal;
  int checksPassed;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelClear();
    for (int r = 0; r < 32; r++) begin
      modelPend[r] = 0;
      modelLong[r] = 0;
      modelCnt[r]  = 0;
    end
  endfunction

  // Applies one clock edge to the model. The events are processed from
  // lowest to highest priority, so a later event overrides an earlier one
  // on the same register.
  function automatic void modelEdge(stim_t s);
    if (s.fl) begin
      modelClear();
    end else begin
      if (s.adv) begin
        for (int r = 1; r < 32; r++) begin
          if (modelPend[r] != 0 && modelCnt[r] > 0) modelCnt[r] = modelCnt[r] - 1;
        end
      end
      if (s.ld && s.ldst != 0) modelLong[s.ldst] = 0;
      if (s.rv && s.rdst != 0) begin
        modelPend[s.rdst] = 0;
        modelLong[s.rdst] = 0;
        modelCnt[s.rdst]  = 0;
      end
      if (s.iv && s.iw && s.idst != 0) begin
        modelPend[s.idst] = 1;
        modelLong[s.idst] = int'(s.il);
        modelCnt[s.idst]  = int'(s.ilat);
      end
    end
  endfunction

  // Computes the outputs the DUT should show for operands rs and rt, given
  // the model's current state.
  function automatic exp_t modelQuery(logic [4:0] rs, logic [4:0] rt);
    exp_t e;
    int   anyPend;
    e.rsP = (rs != 0) && (modelPend[rs] != 0);
    e.rtP = (rt != 0) && (modelPend[rt] != 0);
    e.rsS = e.rsP && (modelCnt[rs] != 0 || modelLong[rs] != 0);
    e.rtS = e.rtP && (modelCnt[rt] != 0 || modelLong[rt] != 0);
    anyPend = 0;
    for (int r = 1; r < 32; r++) begin
      if (modelPend[r] != 0) anyPend = 1;
    end
    e.busy = (anyPend != 0);
    return e;
  endfunction

  function automatic stim_t idleStim(logic [4:0] rs, logic [4:0] rt);
    stim_t s;
    s.iv = 0; s.iw = 0; s.idst = 0; s.ilat = 0; s.il = 0;
    s.adv = 1; s.ld = 0; s.ldst = 0; s.rv = 0; s.rdst = 0;
    s.fl = 0; s.rs = rs; s.rt = rt;
    return s;
  endfunction

  function automatic stim_t issueStim(logic [4:0] dst, logic [1:0] lat, logic lng,
                                      logic [4:0] rs, logic [4:0] rt);
    stim_t s;
    s = idleStim(rs, rt);
    s.iv = 1; s.iw = 1; s.idst = dst; s.ilat = lat; s.il = lng;
    return s;
  endfunction

  // Called just after a rising edge. Drives one cycle of inputs and pushes
  // the outputs expected before the next edge. It then waits for that edge
  // and advances the model.
  task automatic applyStimulus(input stim_t s);
    issue_valid  = s.iv;
    issue_wr     = s.iw;
    issue_dst    = s.idst;
    issue_lat    = s.ilat;
    issue_long   = s.il;
    pipe_adv     = s.adv;
    long_done    = s.ld;
    long_dst     = s.ldst;
    retire_valid = s.rv;
    retire_dst   = s.rdst;
    flush        = s.fl;
    id_rs        = s.rs;
    id_rt        = s.rt;
    expQ.push_back(modelQuery(s.rs, s.rt));
    @(posedge clk);
    if (rst) modelClear();
    else     modelEdge(s);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic want);
    checksTotal++;
    if (act === want) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: at each falling edge, compare the DUT outputs against the
  // oldest pending expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("rs_pending", rs_pending, e.rsP);
      checkOutput("rt_pending", rt_pending, e.rtP);
      checkOutput("rs_stall",   rs_stall,   e.rsS);
      checkOutput("rt_stall",   rt_stall,   e.rtS);
      checkOutput("busy_any",   busy_any,   e.busy);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    checksTotal  = 0;
    checksPassed = 0;
    modelClear();
    rst = 1'b1;
    issue_valid = 0; issue_wr = 0; issue_dst = 0; issue_lat = 0; issue_long = 0;
    pipe_adv = 0; long_done = 0; long_dst = 0; retire_valid = 0; retire_dst = 0;
    flush = 0; id_rs = 0; id_rt = 0;

    // Check the outputs while reset is held.
    @(posedge clk); #1;
    applyStimulus(idleStim(5'd5, 5'd0));
    rst = 1'b0;
    applyStimulus(idleStim(5'd5, 5'd0));

    // Issue an op with latency 2, count it down, then retire it.
    applyStimulus(issueStim(5'd8, 2'd2, 1'b0, 5'd8, 5'd0));
    repeat (3) applyStimulus(idleStim(5'd8, 5'd0));
    s = idleStim(5'd8, 5'd0); s.rv = 1; s.rdst = 5'd8;
    applyStimulus(s);
    applyStimulus(idleStim(5'd8, 5'd0));

    // Frozen pipeline: the countdown must hold while pipe_adv is low.
    s = issueStim(5'd9, 2'd1, 1'b0, 5'd9, 5'd0); s.adv = 0;
    applyStimulus(s);
    s = idleStim(5'd9, 5'd0); s.adv = 0;
    repeat (3) applyStimulus(s);
    repeat (2) applyStimulus(idleStim(5'd9, 5'd0));

    // Long op: it stalls until long_done, whatever pipe_adv does.
    applyStimulus(issueStim(5'd3, 2'd0, 1'b1, 5'd0, 5'd3));
    for (int i = 0; i < 10; i++) begin
      s = idleStim(5'd9, 5'd3); s.adv = 1'($urandom_range(0, 1));
      applyStimulus(s);
    end
    s = idleStim(5'd9, 5'd3); s.ld = 1; s.ldst = 5'd3;
    applyStimulus(s);
    repeat (2) applyStimulus(idleStim(5'd9, 5'd3));
    s = idleStim(5'd0, 5'd3); s.rv = 1; s.rdst = 5'd3;
    applyStimulus(s);
    s = idleStim(5'd0, 5'd3); s.rv = 1; s.rdst = 5'd9;
    applyStimulus(s);
    applyStimulus(idleStim(5'd9, 5'd3));

    // Retire and issue on the same register in one cycle: the issue wins.
    applyStimulus(issueStim(5'd4, 2'd1, 1'b0, 5'd4, 5'd0));
    applyStimulus(idleStim(5'd4, 5'd0));
    s = issueStim(5'd4, 2'd1, 1'b0, 5'd4, 5'd0); s.rv = 1; s.rdst = 5'd4;
    applyStimulus(s);
    applyStimulus(idleStim(5'd4, 5'd0));
    applyStimulus(issueStim(5'd0, 2'd3, 1'b1, 5'd0, 5'd4));
    applyStimulus(idleStim(5'd0, 5'd4));

    // Flush issued in the same cycle as a new issue.
    applyStimulus(issueStim(5'd2, 2'd3, 1'b0, 5'd2, 5'd7));
    applyStimulus(issueStim(5'd7, 2'd1, 1'b1, 5'd2, 5'd7));
    applyStimulus(issueStim(5'd31, 2'd2, 1'b0, 5'd31, 5'd7));
    s = issueStim(5'd6, 2'd1, 1'b0, 5'd6, 5'd31); s.fl = 1;
    applyStimulus(s);
    applyStimulus(idleStim(5'd6, 5'd31));
    applyStimulus(idleStim(5'd2, 5'd7));

    // Assert reset mid-countdown: the outputs must fall before the next edge.
    applyStimulus(issueStim(5'd10, 2'd3, 1'b0, 5'd10, 5'd0));
    applyStimulus(idleStim(5'd10, 5'd0));
    #1;
    rst = 1'b1;
    modelClear();
    expQ.push_back(modelQuery(5'd10, 5'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(idleStim(5'd10, 5'd0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = idleStim(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      s.iv   = ($urandom_range(0, 99) < 60);
      s.iw   = ($urandom_range(0, 99) < 80);
      s.idst = 5'($urandom_range(0, 31));
      s.ilat = 2'($urandom_range(0, 3));
      s.il   = ($urandom_range(0, 99) < 15);
      s.adv  = ($urandom_range(0, 99) < 70);
      s.ld   = ($urandom_range(0, 99) < 20);
      s.ldst = 5'($urandom_range(0, 31));
      s.rv   = ($urandom_range(0, 99) < 50);
      s.rdst = 5'($urandom_range(0, 31));
      s.fl   = ($urandom_range(0, 99) < 3);
      applyStimulus(s);
    end

    applyStimulus(idleStim(5'd0, 5'd0));
    repeat (2) @(negedge clk);
    if (expQ.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL drain: got %0d outstanding expectations, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
